spi_master_param: RTL

Parametrised full-duplex SPI master that shifts a `DATA_W`-bit word out on `spi_mosi` while capturing a word from `spi_miso`. It supports all four CPOL/CPHA modes, MSB- or LSB-first order and a programmable SCLK divider. It uses a start/busy/done handshake, replacing the fixed 16-bit single-mode SPI block. It sits between the system-side register logic, which runs on `clk`, and the off-chip SPI pins.

---
 rtl/spi_master_param.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// SPI master: full-duplex DATA_W-bit word, CPOL/CPHA modes 0-3, MSB/LSB first, SCLK half-period CLK_DIV.
// Latency: start edge to done pulse is 1+(2*DATA_W+1)*CLK_DIV clk cycles; every output is registered.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, never queued.
module spi_master_param #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int TMR_W = $clog2(CLK_DIV + 1);
  localparam int EDG_W = $clog2(2 * DATA_W + 1);
  // LEAD runs one cycle longer than the other phases: CS drops one cycle after the start edge.
  localparam logic [TMR_W-1:0] H_LEAD = TMR_W'(CLK_DIV);
  localparam logic [TMR_W-1:0] H_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [EDG_W-1:0] EDGES  = EDG_W'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [EDG_W-1:0]    edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [1:0]          mode_q, mode_d;
  logic                lsb_q, lsb_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

  logic                edge_ev;
  logic [EDG_W-1:0]    edge_n;
  logic                sample;
  logic                shift;

  // Next-state and output logic: phase sequencing plus the per-SCLK-edge sample/shift work.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    mode_d    = mode_q;
    lsb_d     = lsb_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    bit_cnt_d = bit_cnt_q;
    edge_ev   = 1'b0;
    edge_n    = edge_q + EDG_W'(1);
    sample    = 1'b0;
    shift     = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = mode[1];
        if (start) begin
          state_d   = LEAD;
          tmr_d     = '0;
          edge_d    = '0;
          tx_d      = tx_data;
          mode_d    = mode;
          lsb_d     = lsb_first;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      LEAD: begin
        cs_d   = 1'b0;
        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
        if (tmr_q == H_LEAD) edge_ev = 1'b1;
        else                 tmr_d   = tmr_q + TMR_W'(1);
      end
      XFER: begin
        if (tmr_q == H_LAST) edge_ev = 1'b1;
        else                 tmr_d   = tmr_q + TMR_W'(1);
      end
      TRAIL: begin
        sclk_d = mode_q[1];
        if (tmr_q == H_LAST) begin
          state_d   = GAP;
          tmr_d     = '0;
          cs_d      = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      GAP: begin
        if (tmr_q == H_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Odd edges are leading. CPHA=0 samples odd edges and shifts on the following even ones;
    // CPHA=1 samples even edges and shifts on the odd edge after, so MOSI never moves on a sample edge.
    if (edge_ev) begin
      tmr_d  = '0;
      edge_d = edge_n;
      sclk_d = ~sclk_q;
      sample = mode_q[0] ? ~edge_n[0] : edge_n[0];
      shift  = mode_q[0] ? (edge_n[0] && (edge_n != EDG_W'(1)))
                         : (~edge_n[0] && (edge_n != EDGES));
      if (sample) begin
        rx_d      = lsb_q ? {spi_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (shift) begin
        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
      end
      state_d = (edge_n == EDGES) ? TRAIL : XFER;
    end
  end

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      mode_q    <= 2'b00;
      lsb_q     <= 1'b0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      mode_q    <= mode_d;
      lsb_q     <= lsb_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_cs   = cs_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign bit_cnt  = bit_cnt_q;

endmodule
